// File: rtl/arcade_ce_gen.sv
// Multi-channel fractional clock-enable generator: each channel emits ce_p/ce_n
// pulses at an average rate of inc/modulus per clk_sys cycle.
module arcade_ce_gen #(
    parameter int unsigned NUM_CH = 3,
    parameter int unsigned ACC_W  = 16
) (
    input  logic                    clk_sys,
    input  logic                    reset_n,
    input  logic                    pause,
    input  logic                    resync,
    input  logic [NUM_CH*ACC_W-1:0] inc,
    input  logic [NUM_CH*ACC_W-1:0] modulus,
    output logic [NUM_CH-1:0]       ce_p,
    output logic [NUM_CH-1:0]       ce_n,
    output logic [NUM_CH-1:0]       active
);

    localparam int unsigned SUM_W = ACC_W + 1;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        logic [ACC_W-1:0] inc_w;
        logic [ACC_W-1:0] mod_w;
        logic [ACC_W-1:0] inc_eff;
        logic [ACC_W-1:0] half;
        logic [ACC_W-1:0] acc_q;
        logic [ACC_W-1:0] acc_d;
        logic [SUM_W-1:0] sum;
        logic [SUM_W-1:0] wrap_rem;
        logic [SUM_W-1:0] inc_x2;
        logic             enabled;
        logic             no_mid;
        logic             ce_p_q;
        logic             ce_p_d;
        logic             ce_n_q;
        logic             ce_n_d;
        logic             active_q;

        assign inc_w    = inc[k*ACC_W +: ACC_W];
        assign mod_w    = modulus[k*ACC_W +: ACC_W];
        assign enabled  = (mod_w != '0) && (inc_w != '0);
        // An increment larger than the modulus saturates to one pulse per cycle.
        assign inc_eff  = (inc_w > mod_w) ? mod_w : inc_w;
        assign half     = mod_w >> 1;
        assign sum      = SUM_W'(acc_q) + SUM_W'(inc_eff);
        assign wrap_rem = sum - SUM_W'(mod_w);
        assign inc_x2   = {inc_w, 1'b0};
        assign no_mid   = inc_x2 > SUM_W'(mod_w);

        always_comb begin
            acc_d  = acc_q;
            ce_p_d = 1'b0;
            ce_n_d = 1'b0;
            if (resync || !enabled) begin
                acc_d = '0;
            end else if (pause) begin
                acc_d = acc_q;
            end else if (acc_q >= mod_w) begin
                // Modulus was lowered below the current phase: restart the period.
                acc_d  = '0;
                ce_p_d = 1'b1;
            end else if (sum >= SUM_W'(mod_w)) begin
                acc_d  = ACC_W'(wrap_rem);
                ce_p_d = 1'b1;
                ce_n_d = !no_mid && (wrap_rem >= SUM_W'(half));
            end else begin
                acc_d  = ACC_W'(sum);
                ce_n_d = !no_mid && (acc_q < half) && (sum >= SUM_W'(half));
            end
        end

        always_ff @(posedge clk_sys or negedge reset_n) begin
            if (!reset_n) begin
                acc_q    <= '0;
                ce_p_q   <= 1'b0;
                ce_n_q   <= 1'b0;
                active_q <= 1'b0;
            end else begin
                acc_q    <= acc_d;
                ce_p_q   <= ce_p_d;
                ce_n_q   <= ce_n_d;
                active_q <= enabled && !pause;
            end
        end

        assign ce_p[k]   = ce_p_q;
        assign ce_n[k]   = ce_n_q;
        assign active[k] = active_q;
    end

endmodule
